fsm_seq_tx: RTL and testbench
=============================

# fsm_seq_tx

Serial pattern transmitter that drives the one-bit `x` stream consumed by the sequence-detector FSM. It loads a parallel pattern, shifts it out MSB-first for a programmable number of passes with an optional idle gap between passes, and counts detector hits reported back on `det_y`. It sits in front of the detector in bring-up and self-test builds, and exposes its present and next state for debug probing.

## Interface
- `WIDTH`, 8: pattern length in bits (≥2).
- `REP_W`, 4: width of the repeat field.
- `GAP_LEN`, 2: idle cycles between passes; 0 means back-to-back passes.
- `MCNT_W`, 4: width of the match counter.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin transmission; sampled only in IDLE.
- `abort`  in  1  synchronous cancel; honoured in any non-IDLE state.
- `pattern`  in  WIDTH  bits to send, captured on an accepted `start`.
- `reps`  in  REP_W  extra passes; the number of passes is `reps`+1, captured on an accepted `start`.
- `det_y`  in  1  detector output fed back for hit counting.
- `x`  out  1  serial data, MSB first.
- `x_valid`  out  1  high while `x` carries a pattern bit.
- `busy`  out  1  high when the state is not IDLE.
- `done`  out  1  one-cycle pulse after the last bit of the last pass.
- `match_cnt`  out  MCNT_W  number of `det_y` hits, saturating.
- `ps1`  out  2  present state encoding.
- `ns1`  out  2  next state encoding, combinational.

## Operation
- State encoding: IDLE=0, SHIFT=1, GAP=2, DONE=3.
- **IDLE**
  - `start`=1 captures `pattern` into the shift register and `reps` into the pass counter.
  - Clears `match_cnt` and the bit counter, then moves to SHIFT.
- **SHIFT**
  - `x` = shift register MSB and `x_valid`=1.
  - The register shifts left by one and the bit counter increments each cycle.
  - After the WIDTH-th bit:
    - If passes remain and GAP_LEN>0: go to GAP.
    - If passes remain and GAP_LEN=0: stay in SHIFT with the pattern reloaded from the captured copy.
    - Otherwise: go to DONE.
  - The pass counter decrements at the end of each non-final pass.
- **GAP**
  - `x`=0 and `x_valid`=0 for exactly GAP_LEN cycles.
  - Reload the shift register, then go to SHIFT.
- **DONE**
  - `done`=1 for one cycle, then go to IDLE.
- **abort**
  - In SHIFT, GAP or DONE: next state is IDLE. No `done` pulse is produced and `match_cnt` holds its value.
  - `abort` has priority over all other transitions.
  - In IDLE, `abort` is ignored; if `start` and `abort` are both high in IDLE, `start` wins.
- `start` is ignored while `busy`=1. There is no queueing.
- `match_cnt` increments on every cycle with `det_y`=1 while state is SHIFT, GAP or DONE. It saturates at 2^MCNT_W−1 and does not wrap.
- In IDLE, `x`=0 and `x_valid`=0.
- Reset (`rst`=0, asynchronous) forces:
  - state to IDLE, with `ps1`=0;
  - `x`, `x_valid`, `busy` and `done` to 0;
  - `match_cnt`, the shift register and all counters to 0.
- With `rst`=0, `ns1` also reads 0.
- Reset asserted mid-transmission terminates the transmission immediately, with no `done` pulse.

## Timing
- Latency: `start` sampled at edge E0 puts the first bit on `x` in the cycle after E0.
- One pass with `reps`=0 gives `x_valid` high for cycles 1..WIDTH and `done` in cycle WIDTH+1.
- Total cycles from `start` to `done`: (`reps`+1)·WIDTH + `reps`·GAP_LEN + 1.
- `busy` rises the cycle after an accepted `start` and falls the cycle after `done`.
- A new `start` is accepted no earlier than the first IDLE cycle after `done`.
- `x`, `x_valid`, `busy`, `done` and `ps1` are registered or decoded from registered state only, with no input-to-output combinational path. `ns1` is the exception.

## Test plan
- WIDTH=8, `pattern`=8'hB2, `reps`=0, `start` pulse → `x` = 1,0,1,1,0,0,1,0 in cycles 1–8 with `x_valid`=1; `done`=1 in cycle 9; `busy`=0 from cycle 10.
- `pattern`=8'hB2, `reps`=2, GAP_LEN=2 → three identical 8-bit bursts, each separated by 2 cycles with `x_valid`=0; `done` in cycle 29; `ps1` sequence 1→2→1→2→1→3→0.
- GAP_LEN=0, `reps`=1, `pattern`=8'hF0 → 16 contiguous valid bits F0F0; `done` in cycle 17.
- `start` pulsed again at cycle 4 with `pattern`=8'h00 → ignored; the 8'hB2 transmission completes unchanged.
- `abort` at cycle 4 → state IDLE, `x_valid`=0 from cycle 5, no `done`. Separately, `rst`=0 at cycle 5 → all outputs 0 immediately, without waiting for a clock edge.
- MCNT_W=4, `det_y` held high for 20 busy cycles → `match_cnt` saturates at 15. The next accepted `start` clears it to 0.

Source files
------------

// File: rtl/fsm_seq_tx.sv
// rtl/fsm_seq_tx.sv - serial pattern transmitter feeding the sequence detector
//
// Purpose:
//   Loads a parallel pattern and shifts it out MSB first on x for reps+1
//   passes. Passes are separated by GAP_LEN idle cycles. The block counts
//   det_y hits while busy and exposes present/next state for debug probing.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   start      in   begin transmission (sampled in IDLE only)
//   abort      in   synchronous cancel, honoured outside IDLE
//   pattern    in   WIDTH bits to send, captured on accepted start
//   reps       in   extra passes (passes = reps+1), captured on accepted start
//   det_y      in   detector hit feedback
//   x          out  serial data, MSB first
//   x_valid    out  x carries a pattern bit
//   busy       out  state is not IDLE
//   done       out  one-cycle pulse after the last bit of the last pass
//   match_cnt  out  saturating count of det_y hits
//   ps1        out  present state (IDLE=0 SHIFT=1 GAP=2 DONE=3)
//   ns1        out  next state, combinational, 0 while in reset
module fsm_seq_tx #(
  parameter int WIDTH   = 8,
  parameter int REP_W   = 4,
  parameter int GAP_LEN = 2,
  parameter int MCNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  pattern,
  input  logic [REP_W-1:0]  reps,
  input  logic              det_y,
  output logic              x,
  output logic              x_valid,
  output logic              busy,
  output logic              done,
  output logic [MCNT_W-1:0] match_cnt,
  output logic [1:0]        ps1,
  output logic [1:0]        ns1
);

  localparam int BIT_W = $clog2(WIDTH);
  localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [MCNT_W-1:0] MCNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    sreg_q, sreg_d;   // bits still to send this pass
  logic [WIDTH-1:0]    pat_q, pat_d;     // captured copy used for reloads
  logic [REP_W-1:0]    pass_q, pass_d;   // passes remaining after the current one
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [MCNT_W-1:0]   mcnt_q, mcnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      pat_q   <= '0;
      pass_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      pat_q   <= pat_d;
      pass_q  <= pass_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      mcnt_q  <= mcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    pat_d   = pat_q;
    pass_d  = pass_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    mcnt_d  = mcnt_q;

    // Hits are counted in every busy state, including the cycle abort is seen.
    if ((state_q != IDLE) && det_y && (mcnt_q != MCNT_MAX)) begin
      mcnt_d = mcnt_q + MCNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          sreg_d  = pattern;
          pat_d   = pattern;
          pass_d  = reps;
          bit_d   = '0;
          gap_d   = '0;
          mcnt_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        bit_d  = bit_q + BIT_W'(1);
        if (bit_q == BIT_LAST) begin
          bit_d = '0;
          if (pass_q != '0) begin
            pass_d = pass_q - REP_W'(1);
            if (GAP_LEN > 0) begin
              gap_d   = '0;
              state_d = GAP;
            end else begin
              // Back-to-back passes: next pass starts on the very next cycle.
              sreg_d = pat_q;
            end
          end else begin
            state_d = DONE;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          sreg_d  = pat_q;
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort overrides every other transition but leaves match_cnt untouched.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  // All serial/status outputs decode registered state only.
  assign x         = (state_q == SHIFT) & sreg_q[WIDTH-1];
  assign x_valid   = (state_q == SHIFT);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign match_cnt = mcnt_q;
  assign ps1       = state_q;
  assign ns1       = rst ? state_d : IDLE;

endmodule

// File: tb/tb_fsm_seq_tx.sv
// tb/tb_fsm_seq_tx.sv - self-checking bench for fsm_seq_tx
module tb_fsm_seq_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] reps;
  logic       det_y;

  logic       x2, xv2, busy2, done2;
  logic [3:0] mc2;
  logic [1:0] ps2, ns2;
  logic       x0, xv0, busy0, done0;
  logic [3:0] mc0;
  logic [1:0] ps0, ns0;

  int n_vec;
  int n_err;

  fsm_seq_tx #(.WIDTH(8), .REP_W(4), .GAP_LEN(2), .MCNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pattern),
    .reps(reps), .det_y(det_y), .x(x2), .x_valid(xv2), .busy(busy2),
    .done(done2), .match_cnt(mc2), .ps1(ps2), .ns1(ns2)
  );

  fsm_seq_tx #(.WIDTH(8), .REP_W(4), .GAP_LEN(0), .MCNT_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pattern),
    .reps(reps), .det_y(det_y), .x(x0), .x_valid(xv0), .busy(busy0),
    .done(done0), .match_cnt(mc0), .ps1(ps0), .ns1(ns0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each trace entry is one output cycle: [3:2] state code, [1] x, [0] x_valid.
  typedef logic [3:0] trace_t [$];

  function automatic trace_t build(input logic [7:0] pat, input int r, input int gap);
    trace_t t;
    for (int p = 0; p <= r; p++) begin
      for (int b = 7; b >= 0; b--) t.push_back({2'd1, pat[b], 1'b1});
      if (p < r) for (int g = 0; g < gap; g++) t.push_back(4'b1000);
    end
    t.push_back(4'b1100);
    return t;
  endfunction

  trace_t q2;
  trace_t q0;
  int     m2;
  int     m0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a queue of the remaining busy cycles, popped on each edge.
  initial begin
    q2 = {}; q0 = {}; m2 = 0; m0 = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        q2.delete(); q0.delete(); m2 = 0; m0 = 0;
      end else begin
        if (q2.size() == 0) begin
          if (start) begin q2 = build(pattern, int'(reps), 2); m2 = 0; end
        end else begin
          if (det_y && m2 < 15) m2++;
          if (abort) q2.delete(); else void'(q2.pop_front());
        end
        if (q0.size() == 0) begin
          if (start) begin q0 = build(pattern, int'(reps), 0); m0 = 0; end
        end else begin
          if (det_y && m0 < 15) m0++;
          if (abort) q0.delete(); else void'(q0.pop_front());
        end
      end
    end
  end

  task automatic cmp_dut(input string tag, input logic [3:0] cur, input logic has,
                         input logic [1:0] nxt, input int m,
                         input logic ax, input logic axv, input logic ab, input logic ad,
                         input logic [3:0] amc, input logic [1:0] aps, input logic [1:0] ans);
    logic [3:0] e;
    logic [1:0] ens;
    e = has ? cur : 4'b0000;
    if (!rst)          ens = 2'd0;
    else if (!has)     ens = start ? 2'd1 : 2'd0;
    else if (abort)    ens = 2'd0;
    else               ens = nxt;
    chk({tag, ".x"},         32'(ax),  32'(e[1]));
    chk({tag, ".x_valid"},   32'(axv), 32'(e[0]));
    chk({tag, ".busy"},      32'(ab),  32'(has));
    chk({tag, ".done"},      32'(ad),  32'(e[3:2] == 2'd3));
    chk({tag, ".match_cnt"}, 32'(amc), 32'(m));
    chk({tag, ".ps1"},       32'(aps), 32'(e[3:2]));
    chk({tag, ".ns1"},       32'(ans), 32'(ens));
  endtask

  initial begin
    forever begin
      logic [3:0] c2, c0;
      logic [1:0] n2, n0;
      @(negedge clk);
      c2 = (q2.size() > 0) ? q2[0] : 4'b0;
      n2 = 2'd0;
      if (q2.size() > 1) begin c2 = q2[0]; n2 = q2[1][3:2]; end
      c0 = (q0.size() > 0) ? q0[0] : 4'b0;
      n0 = 2'd0;
      if (q0.size() > 1) begin c0 = q0[0]; n0 = q0[1][3:2]; end
      cmp_dut("gap2", c2, q2.size() > 0, n2, m2, x2, xv2, busy2, done2, mc2, ps2, ns2);
      cmp_dut("gap0", c0, q0.size() > 0, n0, m0, x0, xv0, busy0, done0, mc0, ps0, ns0);
    end
  end

  task automatic go(input logic [7:0] pat, input logic [3:0] r);
    start = 1'b1; pattern = pat; reps = r;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic capture(input int sel, input int ncyc, input int inj_start,
                         input int inj_abort, input int det_last,
                         output logic [31:0] bits, output int done_at,
                         output int idle_at, output logic [31:0] pseq);
    logic xx, vv, dd, bb;
    logic [1:0] pp, last;
    bits = '0; done_at = -1; idle_at = -1; pseq = '0; last = 2'd0;
    for (int c = 1; c <= ncyc; c++) begin
      start = (c == inj_start);
      if (c == inj_start) pattern = 8'h00;
      abort = (c == inj_abort);
      det_y = (c <= det_last);
      @(negedge clk);
      if (sel == 0) begin xx = x2; vv = xv2; dd = done2; bb = busy2; pp = ps2; end
      else          begin xx = x0; vv = xv0; dd = done0; bb = busy0; pp = ps0; end
      if (vv) bits = {bits[30:0], xx};
      if (dd && done_at < 0) done_at = c;
      if (!bb && idle_at < 0) idle_at = c;
      if (pp != last) pseq = {pseq[27:0], 2'b00, pp};
      last = pp;
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; det_y = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while ((busy2 || busy0) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk({name, ".idle_timeout"}, 32'(busy2 || busy0), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] bits, pseq;
    int done_at, idle_at;
    n_vec = 0; n_err = 0;
    rst = 1'b0; start = 1'b0; abort = 1'b0; pattern = '0; reps = '0; det_y = 1'b0;

    // Reset state, with start high to show ns1 is forced to 0.
    repeat (2) @(posedge clk);
    #1 start = 1'b1;
    #1;
    chk("rst.ps1", 32'(ps2), 0);
    chk("rst.ns1", 32'(ns2), 0);
    chk("rst.busy", 32'(busy2), 0);
    chk("rst.match_cnt", 32'(mc2), 0);
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Single pass of B2.
    go(8'hB2, 4'd0);
    capture(0, 12, 0, 0, 0, bits, done_at, idle_at, pseq);
    chk("t1.bits", bits, 32'h0000_00B2);
    chk("t1.done_cycle", 32'(done_at), 32'd9);
    chk("t1.idle_cycle", 32'(idle_at), 32'd10);
    wait_idle("t1");

    // Three passes with 2-cycle gaps.
    go(8'hB2, 4'd2);
    capture(0, 32, 0, 0, 0, bits, done_at, idle_at, pseq);
    chk("t2.bits", bits, 32'h00B2_B2B2);
    chk("t2.done_cycle", 32'(done_at), 32'd29);
    chk("t2.ps_seq", pseq, 32'h0121_2130);
    wait_idle("t2");

    // Back-to-back passes on the GAP_LEN=0 instance, three det hits.
    go(8'hF0, 4'd1);
    capture(1, 20, 0, 0, 3, bits, done_at, idle_at, pseq);
    chk("t3.bits", bits, 32'h0000_F0F0);
    chk("t3.done_cycle", 32'(done_at), 32'd17);
    chk("t3.match_cnt", 32'(mc0), 32'd3);
    wait_idle("t3");

    // Start while busy is ignored.
    go(8'hB2, 4'd0);
    capture(0, 12, 4, 0, 0, bits, done_at, idle_at, pseq);
    chk("t4.bits", bits, 32'h0000_00B2);
    chk("t4.done_cycle", 32'(done_at), 32'd9);
    wait_idle("t4");

    // Abort in cycle 4.
    go(8'hB2, 4'd0);
    capture(0, 10, 0, 4, 0, bits, done_at, idle_at, pseq);
    chk("t5.bits", bits, 32'h0000_000B);
    chk("t5.done_cycle", done_at, 32'hFFFF_FFFF);
    chk("t5.idle_cycle", 32'(idle_at), 32'd5);
    wait_idle("t5");

    // Start and abort together in IDLE: start wins.
    start = 1'b1; abort = 1'b1; pattern = 8'h55; reps = 4'd0;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("t5b.busy", 32'(busy2), 32'd1);
    @(posedge clk); #1;
    wait_idle("t5b");

    // Asynchronous reset mid-transmission (cycle 5).
    go(8'hB2, 4'd0);
    capture(0, 4, 0, 0, 0, bits, done_at, idle_at, pseq);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("t6.x_valid", 32'(xv2), 0);
    chk("t6.busy", 32'(busy2), 0);
    chk("t6.ps1", 32'(ps2), 0);
    chk("t6.ns1", 32'(ns2), 0);
    chk("t6.done", 32'(done2), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // det_y high for 20 busy cycles saturates at 15; next start clears it.
    go(8'hB2, 4'd2);
    capture(0, 32, 0, 0, 20, bits, done_at, idle_at, pseq);
    chk("t7.match_cnt_sat", 32'(mc2), 32'd15);
    chk("t7.match_cnt_sat0", 32'(mc0), 32'd15);
    go(8'hB2, 4'd0);
    @(negedge clk);
    chk("t7.match_cnt_clr", 32'(mc2), 32'd0);
    @(posedge clk); #1;
    wait_idle("t7");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
